// File: rtl/timer_port_arbiter.sv
// Round-robin arbiter sharing the timer register port between two masters.
// m0 = CPU, m1 = DMA/debug; one register transfer per grant.
//
// Ports:
//   clk0, reset              clock (rising edge), async active-high reset
//   m{0,1}_req/_wr/_sel/_wdata  master request, direction, register, data
//   m{0,1}_ack/_rdata        one-cycle completion pulse, read data (held)
//   timer_cmd/_addr/_host_datain  registered command bundle to the timer
//   timer_host_dataout       timer read data, one cycle after a read cmd
//   arb_busy                 high whenever a transfer is in flight
module timer_port_arbiter #(
  parameter int data_size = 32,
  parameter int cmd_size  = 3,
  parameter int padd_size = 24,
  parameter logic [padd_size-1:0] TIMER_BASE = 24'h080020
) (
  input  logic                 clk0,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic                 m0_wr,
  input  logic [1:0]           m0_sel,
  input  logic [data_size-1:0] m0_wdata,
  output logic                 m0_ack,
  output logic [data_size-1:0] m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_wr,
  input  logic [1:0]           m1_sel,
  input  logic [data_size-1:0] m1_wdata,
  output logic                 m1_ack,
  output logic [data_size-1:0] m1_rdata,
  output logic [cmd_size-1:0]  timer_cmd,
  output logic [padd_size-1:0] timer_addr,
  output logic [data_size-1:0] timer_host_datain,
  input  logic [data_size-1:0] timer_host_dataout,
  output logic                 arb_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic [cmd_size-1:0] CMD_IDLE = '0;
  localparam logic [cmd_size-1:0] CMD_RD   = cmd_size'(1);
  localparam logic [cmd_size-1:0] CMD_WR   = cmd_size'(2);

  logic [1:0]           state_q, state_d;
  logic                 last_q, last_d;
  logic                 gnt_q, gnt_d;
  logic                 wr_q, wr_d;
  logic [cmd_size-1:0]  cmd_q, cmd_d;
  logic [padd_size-1:0] addr_q, addr_d;
  logic [data_size-1:0] din_q, din_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic [data_size-1:0] rd0_q, rd0_d;
  logic [data_size-1:0] rd1_q, rd1_d;

  // m1 wins when it is alone, or when both ask and m0 was served last.
  logic                 pick;
  logic                 pick_wr;
  logic [1:0]           pick_sel;
  logic [data_size-1:0] pick_wdata;

  assign pick       = m1_req & (~m0_req | ~last_q);
  assign pick_wr    = pick ? m1_wr    : m0_wr;
  assign pick_sel   = pick ? m1_sel   : m0_sel;
  assign pick_wdata = pick ? m1_wdata : m0_wdata;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    cmd_d   = CMD_IDLE;
    addr_d  = '0;
    din_d   = '0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    unique case (state_q)
      S_IDLE: begin
        if (m0_req | m1_req) begin
          state_d = S_ISSUE;
          gnt_d   = pick;
          last_d  = pick;
          wr_d    = pick_wr;
          cmd_d   = pick_wr ? CMD_WR : CMD_RD;
          addr_d  = TIMER_BASE + padd_size'(pick_sel);
          din_d   = pick_wr ? pick_wdata : '0;
        end
      end
      S_ISSUE: begin
        if (wr_q) begin
          state_d = S_ACK;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
        end else begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        state_d = S_ACK;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        if (gnt_q) rd1_d = timer_host_dataout;
        else       rd0_d = timer_host_dataout;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      cmd_q   <= CMD_IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign timer_cmd         = cmd_q;
  assign timer_addr        = addr_q;
  assign timer_host_datain = din_q;
  assign m0_ack            = ack0_q;
  assign m1_ack            = ack1_q;
  assign m0_rdata          = rd0_q;
  assign m1_rdata          = rd1_q;
  assign arb_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_timer_port_arbiter.sv
// Bench for timer_port_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-schedule reference model.
module tb_timer_port_arbiter;

  localparam int N = 4096;
  localparam logic [23:0] BASE = 24'h080020;

  logic        clk0 = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  wr = '0;
  logic [1:0]  sel [2];
  logic [31:0] wd [2];

  logic        m0_ack, m1_ack, arb_busy;
  logic [31:0] m0_rdata, m1_rdata;
  logic [2:0]  timer_cmd;
  logic [23:0] timer_addr;
  logic [31:0] timer_host_datain;
  logic [31:0] tdout;

  always #5 clk0 = ~clk0;

  timer_port_arbiter dut (
    .clk0(clk0),
    .reset(reset),
    .m0_req(req[0]),
    .m0_wr(wr[0]),
    .m0_sel(sel[0]),
    .m0_wdata(wd[0]),
    .m0_ack(m0_ack),
    .m0_rdata(m0_rdata),
    .m1_req(req[1]),
    .m1_wr(wr[1]),
    .m1_sel(sel[1]),
    .m1_wdata(wd[1]),
    .m1_ack(m1_ack),
    .m1_rdata(m1_rdata),
    .timer_cmd(timer_cmd),
    .timer_addr(timer_addr),
    .timer_host_datain(timer_host_datain),
    .timer_host_dataout(tdout),
    .arb_busy(arb_busy)
  );

  // Timer stand-in: four registers, registered read data, junk otherwise.
  logic [31:0] tregs [4];
  logic        tinit = 1'b0;
  always @(posedge clk0) begin
    if (!tinit) begin
      tregs[0] <= 32'h11111111;
      tregs[1] <= 32'h22222222;
      tregs[2] <= 32'h33333333;
      tregs[3] <= 32'hDEADBEEF;
      tinit    <= 1'b1;
    end else if (timer_cmd == 3'b010) begin
      tregs[timer_addr[1:0]] <= timer_host_datain;
    end
    if (timer_cmd == 3'b001) tdout <= tregs[timer_addr[1:0]];
    else                     tdout <= $urandom;
  end

  // Reference model: on each grant, the whole future of the transfer is
  // written into per-cycle expectation tables.
  logic [2:0]  e_cmd  [N];
  logic [23:0] e_addr [N];
  logic [31:0] e_din  [N];
  logic        e_ack0 [N];
  logic        e_ack1 [N];
  logic        e_busy [N];
  logic        rdu0   [N];
  logic        rdu1   [N];
  logic [31:0] rdv0   [N];
  logic [31:0] rdv1   [N];
  logic [31:0] mregs  [4];
  logic [31:0] erd0, erd1;
  int          ackc [2];
  int          t, idle_at, last;
  int          n_assert, n_fail;
  bit          rmode;

  task automatic clear_from(input int a);
    for (int i = a; i < a + 8 && i < N; i++) begin
      e_cmd[i] = '0; e_addr[i] = '0; e_din[i] = '0;
      e_ack0[i] = 0; e_ack1[i] = 0; e_busy[i] = 0;
      rdu0[i] = 0; rdu1[i] = 0; rdv0[i] = '0; rdv1[i] = '0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=0x%08h expected=0x%08h",
             tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    if (rdu0[t]) erd0 = rdv0[t];
    if (rdu1[t]) erd1 = rdv1[t];
    chk("cmd", 32'(timer_cmd), 32'(e_cmd[t]));
    chk("addr", 32'(timer_addr), 32'(e_addr[t]));
    chk("datain", timer_host_datain, e_din[t]);
    chk("m0_ack", 32'(m0_ack), 32'(e_ack0[t]));
    chk("m1_ack", 32'(m1_ack), 32'(e_ack1[t]));
    chk("busy", 32'(arb_busy), 32'(e_busy[t]));
    chk("m0_rdata", m0_rdata, erd0);
    chk("m1_rdata", m1_rdata, erd1);
  endtask

  task automatic model_cycle();
    int g, ak;
    if (reset || t < idle_at || req == 2'b00) return;
    if (req == 2'b11) g = (last == 1) ? 0 : 1;
    else              g = req[1] ? 1 : 0;
    last = g;
    e_cmd[t+1]  = wr[g] ? 3'b010 : 3'b001;
    e_addr[t+1] = BASE + 24'(sel[g]);
    e_din[t+1]  = wr[g] ? wd[g] : 32'h0;
    e_busy[t+1] = 1;
    e_busy[t+2] = 1;
    if (wr[g]) begin
      mregs[sel[g]] = wd[g];
      ak = t + 2;
    end else begin
      e_busy[t+3] = 1;
      ak = t + 3;
      if (g == 0) begin rdu0[ak] = 1; rdv0[ak] = mregs[sel[g]]; end
      else        begin rdu1[ak] = 1; rdv1[ak] = mregs[sel[g]]; end
    end
    if (g == 0) e_ack0[ak] = 1;
    else        e_ack1[ak] = 1;
    ackc[g] = ak;
    idle_at = ak + 1;
  endtask

  task automatic drive();
    for (int m = 0; m < 2; m++) begin
      if (req[m] && ackc[m] == t - 1) req[m] = 1'b0;
      if (rmode && !req[m] && $urandom_range(0, 2) == 0) begin
        req[m] = 1'b1;
        wr[m]  = 1'($urandom);
        sel[m] = 2'($urandom);
        wd[m]  = $urandom;
      end
    end
  endtask

  task automatic step();
    @(negedge clk0);
    check_all();
    model_cycle();
    @(posedge clk0);
    #1;
    t++;
    drive();
  endtask

  task automatic run_until_idle(input int maxc);
    int k = 0;
    while ((req != 2'b00 || t < idle_at) && k < maxc) begin
      step();
      k++;
    end
    if (k >= maxc) begin
      n_assert++;
      n_fail++;
      $error("FAIL timeout t=%0d observed req=%b expected 00", t, req);
    end
  endtask

  task automatic set_req(input int m, input logic w, input logic [1:0] s,
                         input logic [31:0] d);
    req[m] = 1'b1; wr[m] = w; sel[m] = s; wd[m] = d;
  endtask

  initial begin
    sel[0] = '0; sel[1] = '0; wd[0] = '0; wd[1] = '0;
    mregs[0] = 32'h11111111; mregs[1] = 32'h22222222;
    mregs[2] = 32'h33333333; mregs[3] = 32'hDEADBEEF;
    for (int i = 0; i < N; i += 8) clear_from(i);
    erd0 = '0; erd1 = '0; ackc[0] = -1; ackc[1] = -1;
    t = 0; idle_at = 0; last = 1; n_assert = 0; n_fail = 0; rmode = 0;

    repeat (3) step();
    reset = 1'b0;

    // m0 write to the period register
    set_req(0, 1'b1, 2'd2, 32'h00000010);
    run_until_idle(20);

    // m1 read of the snapshot register
    set_req(1, 1'b0, 2'd3, 32'h0);
    run_until_idle(20);

    // simultaneous requests, four rounds
    for (int r = 0; r < 4; r++) begin
      set_req(0, 1'b0, 2'(r), 32'h0);
      set_req(1, 1'b1, 2'(r + 1), 32'hA5A50000 + 32'(r));
      run_until_idle(40);
    end

    // m1 keeps requesting while m0 re-requests: alternation on held req
    set_req(0, 1'b1, 2'd1, 32'h0BADF00D);
    set_req(1, 1'b1, 2'd0, 32'h00C0FFEE);
    step();
    step();
    set_req(0, 1'b1, 2'd1, 32'h0BADF00E);
    run_until_idle(40);

    // reset in the capture cycle of an m1 read, then the read retries
    set_req(1, 1'b0, 2'd2, 32'h0);
    step();
    step();
    #1 reset = 1'b1;
    #1;
    chk("rst_cmd", 32'(timer_cmd), 32'h0);
    chk("rst_addr", 32'(timer_addr), 32'h0);
    chk("rst_datain", timer_host_datain, 32'h0);
    chk("rst_ack0", 32'(m0_ack), 32'h0);
    chk("rst_ack1", 32'(m1_ack), 32'h0);
    chk("rst_busy", 32'(arb_busy), 32'h0);
    chk("rst_rd0", m0_rdata, 32'h0);
    chk("rst_rd1", m1_rdata, 32'h0);
    clear_from(t);
    erd0 = '0; erd1 = '0; last = 1; idle_at = t;
    ackc[0] = -1; ackc[1] = -1;
    step();
    reset = 1'b0;
    run_until_idle(20);

    // m0 back-to-back writes
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, 2'(i), 32'h1000 + 32'(i));
      for (int k = 0; k < 10 && req[0]; k++) step();
    end
    run_until_idle(20);

    // quiet period
    repeat (100) step();

    // random traffic
    rmode = 1;
    repeat (2500) step();
    rmode = 0;
    run_until_idle(50);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
